// File: rtl/arbiter_merge.sv
// N-to-1 round-robin merger with one registered output stage.
// The output message tags each payload with its source port index in the MSBs.
module arbiter_merge #(
  parameter int p_nbits   = 8,
  parameter int p_ninputs = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_ninputs-1:0]               valid,
  output logic [p_ninputs-1:0]               ready_out,
  input  logic [(p_nbits-$clog2(p_ninputs))*p_ninputs-1:0] message_in,
  output logic                               valid_out,
  input  logic                               ready,
  output logic [p_nbits-1:0]                 message_out
);

  localparam int c_idx = $clog2(p_ninputs);
  localparam int c_pl  = p_nbits - c_idx;

  logic [c_idx-1:0] ptr;
  logic [c_idx-1:0] grant;
  logic             any;
  logic             can_accept;
  logic             accept;
  logic [c_pl-1:0]  payload;

  assign can_accept = !valid_out || ready;

  // Search starts at ptr and wraps with a true modulo for any port count
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    any   = 1'b0;
    for (int k = 0; k < p_ninputs; k++) begin
      j = int'(ptr) + k;
      if (j >= p_ninputs) j = j - p_ninputs;
      if (!any && valid[j]) begin
        any   = 1'b1;
        grant = c_idx'(j);
      end
    end
  end

  always_comb begin
    ready_out = '0;
    if (can_accept && any && !reset)
      ready_out[grant] = 1'b1;
  end

  assign accept  = |ready_out;
  assign payload = message_in[int'(grant)*c_pl +: c_pl];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out   <= 1'b0;
      message_out <= '0;
      ptr         <= '0;
    end else if (accept) begin
      valid_out   <= 1'b1;
      message_out <= {grant, payload};
      ptr         <= (int'(grant) == p_ninputs - 1) ? '0 : grant + 1'b1;
    end else if (ready) begin
      valid_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_merge.sv
// Scoreboard bench for arbiter_merge: 8-port main instance plus
// a 5-port instance exercising the non-power-of-two wrap.
module tb_arbiter_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  valid;
  logic [7:0]  ready_out;
  logic [39:0] message_in;
  logic        valid_out;
  logic        ready;
  logic [7:0]  message_out;

  logic [4:0]  valid5;
  logic [4:0]  ready_out5;
  logic [24:0] message_in5;
  logic        valid_out5;
  logic        ready5;
  logic [7:0]  message_out5;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic       m_vo;
  int         m_ptr;
  int         gd;

  always #5 clk = ~clk;

  arbiter_merge #(.p_nbits(8), .p_ninputs(8)) u_dut (
    .clk(clk), .reset(reset),
    .valid(valid), .ready_out(ready_out),
    .message_in(message_in),
    .valid_out(valid_out), .ready(ready),
    .message_out(message_out)
  );

  arbiter_merge #(.p_nbits(8), .p_ninputs(5)) u_dut5 (
    .clk(clk), .reset(reset),
    .valid(valid5), .ready_out(ready_out5),
    .message_in(message_in5),
    .valid_out(valid_out5), .ready(ready5),
    .message_out(message_out5)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  // One cycle: drive, predict ready_out, drain/compare, update model.
  task automatic step(input logic [7:0] v, input logic r,
                      input logic rst, input logic [39:0] pl,
                      output int g_obs);
    int g;
    int j;
    logic [7:0] exp_rdy;
    logic [7:0] m;
    @(negedge clk);
    valid = v; ready = r; reset = rst; message_in = pl;
    #1;
    g = -1;
    for (int k = 0; k < 8; k++) begin
      j = (m_ptr + k) % 8;
      if (v[j] && g < 0) g = j;
    end
    exp_rdy = '0;
    if (!rst && (!m_vo || r) && g >= 0) exp_rdy[g] = 1'b1;
    check("ready_out", {24'd0, ready_out}, {24'd0, exp_rdy});
    check("valid_out", {31'd0, valid_out}, {31'd0, m_vo});
    g_obs = -1;
    for (int k = 0; k < 8; k++)
      if (ready_out[k]) g_obs = k;
    if (m_vo && q.size() > 0) begin
      if (r && !rst) begin
        m = q.pop_front();
        check("msg_drain", {24'd0, message_out}, {24'd0, m});
      end else if (!r) begin
        check("msg_hold", {24'd0, message_out}, {24'd0, q[0]});
      end
    end
    if (rst) begin
      m_vo = 1'b0; m_ptr = 0; q.delete();
    end else if (exp_rdy != 0) begin
      q.push_back({3'(g), pl[g*5 +: 5]});
      m_vo  = 1'b1;
      m_ptr = (g + 1) % 8;
    end else if (r) begin
      m_vo = 1'b0;
    end
  endtask

  initial begin
    logic [39:0] pl;
    logic [4:0]  prev5;
    int g;
    reset = 1'b1; valid = '1; ready = 1'b0; message_in = '0;
    valid5 = '0; ready5 = 1'b1; message_in5 = '0;
    m_vo = 1'b0; m_ptr = 0;
    repeat (2) @(posedge clk);

    // Reset held with all inputs valid
    step(8'hFF, 1'b1, 1'b1, rnd(), g);
    check("rst_msg", {24'd0, message_out}, 32'd0);

    // Round-robin: first grant after reset is input 0
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b0, rnd(), g);
      check("rr_grant", g, i % 8);
    end

    // Backpressure: output full, ready low
    for (int i = 0; i < 3; i++)
      step(8'hFF, 1'b0, 1'b0, rnd(), g);
    step(8'hFF, 1'b1, 1'b0, rnd(), g);
    check("resume_grant", g, 2);

    // Single source, port 5 payload 0x13
    pl = rnd();
    pl[25 +: 5] = 5'h13;
    step(8'b0010_0000, 1'b1, 1'b0, pl, g);
    check("single_grant", g, 5);
    @(posedge clk);
    #1;
    check("single_msg", {24'd0, message_out}, 32'h0000_00B3);

    // Wrap/skip from ptr 6
    step(8'b0000_0101, 1'b1, 1'b0, rnd(), g);
    check("wrap_grant", g, 0);
    step(8'b0000_0101, 1'b1, 1'b0, rnd(), g);
    check("skip_grant", g, 2);

    // Reset mid-stream while output is stalled
    step(8'hFF, 1'b0, 1'b0, rnd(), g);
    step(8'hFF, 1'b0, 1'b1, rnd(), g);
    step(8'h00, 1'b1, 1'b0, rnd(), g);
    step(8'hFF, 1'b1, 1'b0, rnd(), g);
    check("post_rst_grant", g, 0);

    // 5-port instance: grants wrap 4 -> 0
    prev5 = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      valid5 = '1; ready5 = 1'b1;
      message_in5 = 25'($urandom());
      #1;
      check("rr5_grant", {27'd0, ready_out5}, 32'(1 << (i % 5)));
      if (i > 0) begin
        check("rr5_idx", {29'd0, message_out5[7:5]}, 32'((i - 1) % 5));
        check("rr5_pl", {27'd0, message_out5[4:0]}, {27'd0, prev5});
      end
      prev5 = message_in5[(i % 5)*5 +: 5];
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
